// File: rtl/m68kwb_pkg.sv
// Shared types and helpers for the 68000-to-Wishbone bridge.
package m68kwb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ACKD = 2'd2,
        FAIL = 2'd3
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // Big-endian 68k: UDS is the even byte, which lands in the high lane of a halfword.
    function automatic logic [3:0] sel_map(input logic a1, input logic uds_n, input logic lds_n);
        return a1 ? {2'b00, ~uds_n, ~lds_n} : {~uds_n, ~lds_n, 2'b00};
    endfunction

endpackage

// File: rtl/wb_timeout.sv
// Loadable 8-bit down-counter used to bound Wishbone wait states.
module wb_timeout (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/m68k_wb_bridge.sv
// Turns one 68000 16-bit bus cycle into one 32-bit Wishbone classic cycle,
// returning DTACK or BERR (including timeout) to the CPU side.
module m68k_wb_bridge
    import m68kwb_pkg::*;
#(
    parameter int unsigned ADR_WIDTH = 24,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic [23:1]          A,
    input  logic [15:0]          D_I,
    output logic [15:0]          D_O,
    input  logic                 AS_n,
    input  logic                 UDS_n,
    input  logic                 LDS_n,
    input  logic                 RW,
    output logic                 DTACK_n,
    output logic                 BERR_n,
    output logic [ADR_WIDTH-1:0] ADR_O,
    output logic [31:0]          DAT_O,
    input  logic [31:0]          DAT_I,
    output logic [3:0]           SEL_O,
    output logic                 WE_O,
    output logic                 CYC_O,
    output logic                 STB_O,
    input  logic                 ACK_I,
    input  logic                 ERR_I
);

    state_t                 state_q, state_d;
    logic [ADR_WIDTH-1:0]   adr_q, adr_d;
    logic [31:0]            dat_q, dat_d;
    logic [3:0]             sel_q, sel_d;
    logic                   we_q, we_d;
    logic                   a1_q, a1_d;
    logic [15:0]            dout_q, dout_d;
    logic                   abort_q, abort_d;
    logic                   abort_now;
    logic                   start;
    logic                   tmo_load;
    logic                   tmo_en;
    logic                   tmo_zero;

    assign start = ~AS_n & (~UDS_n | ~LDS_n);

    wb_timeout u_timeout (
        .clk      (CLK_I),
        .rst      (RST_I),
        .load     (tmo_load),
        .en       (tmo_en),
        .load_val (8'(TIMEOUT)),
        .zero     (tmo_zero)
    );

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        a1_d      = a1_q;
        dout_d    = dout_q;
        abort_d   = abort_q;
        abort_now = abort_q | AS_n;
        tmo_load  = 1'b0;
        tmo_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = BUS;
                    adr_d    = {A[ADR_WIDTH-1:2], 2'b00};
                    we_d     = ~RW;
                    dat_d    = {D_I, D_I};
                    sel_d    = sel_map(A[1], UDS_n, LDS_n);
                    a1_d     = A[1];
                    abort_d  = 1'b0;
                    tmo_load = 1'b1;
                end
            end
            BUS: begin
                // A CPU that gave up mid-cycle still lets the slave finish; the result is discarded.
                abort_d = abort_now;
                if (ERR_I) begin
                    state_d = abort_now ? IDLE : FAIL;
                    we_d    = 1'b0;
                    sel_d   = '0;
                end else if (ACK_I) begin
                    state_d = abort_now ? IDLE : ACKD;
                    if (!we_q && !abort_now) begin
                        dout_d = a1_q ? DAT_I[15:0] : DAT_I[31:16];
                    end
                    we_d    = 1'b0;
                    sel_d   = '0;
                end else if (tmo_zero) begin
                    state_d = abort_now ? IDLE : FAIL;
                    we_d    = 1'b0;
                    sel_d   = '0;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            ACKD, FAIL: begin
                if (AS_n) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            a1_q    <= 1'b0;
            dout_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            a1_q    <= a1_d;
            dout_q  <= dout_d;
            abort_q <= abort_d;
        end
    end

    assign CYC_O   = (state_q == BUS);
    assign STB_O   = (state_q == BUS);
    assign WE_O    = we_q;
    assign SEL_O   = sel_q;
    assign ADR_O   = adr_q;
    assign DAT_O   = dat_q;
    assign D_O     = dout_q;
    assign DTACK_n = (state_q != ACKD);
    assign BERR_n  = (state_q != FAIL);

endmodule

// File: tb/tb_m68k_wb_bridge.sv
// Scoreboard bench for m68k_wb_bridge: directed CPU cycles against a small Wishbone memory slave.
module tb_m68k_wb_bridge;

    logic        clk;
    logic        rst;
    logic [23:1] A;
    logic [15:0] D_I;
    logic [15:0] D_O;
    logic        AS_n, UDS_n, LDS_n, RW;
    logic        DTACK_n, BERR_n;
    logic [23:0] ADR_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I;
    logic [3:0]  SEL_O;
    logic        WE_O, CYC_O, STB_O;
    logic        ACK_I, ERR_I;

    typedef struct {
        logic [23:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
        int          len;
    } wb_exp_t;

    typedef struct {
        logic        err;
        logic        chk_d;
        logic [15:0] d;
    } cpu_exp_t;

    wb_exp_t  wb_q[$];
    cpu_exp_t cpu_q[$];

    int checks = 0;
    int errors = 0;

    logic        ack_en = 1'b1;
    logic        err_en = 1'b0;
    int          wait_cfg = 0;
    int          stb_cnt;
    logic [31:0] mem [0:255];

    m68k_wb_bridge #(.ADR_WIDTH(24), .TIMEOUT(4)) dut (
        .CLK_I   (clk),
        .RST_I   (rst),
        .A       (A),
        .D_I     (D_I),
        .D_O     (D_O),
        .AS_n    (AS_n),
        .UDS_n   (UDS_n),
        .LDS_n   (LDS_n),
        .RW      (RW),
        .DTACK_n (DTACK_n),
        .BERR_n  (BERR_n),
        .ADR_O   (ADR_O),
        .DAT_O   (DAT_O),
        .DAT_I   (DAT_I),
        .SEL_O   (SEL_O),
        .WE_O    (WE_O),
        .CYC_O   (CYC_O),
        .STB_O   (STB_O),
        .ACK_I   (ACK_I),
        .ERR_I   (ERR_I)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave: answers after wait_cfg wait states, combinationally in the answering cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) stb_cnt <= 0;
        else     stb_cnt <= STB_O ? stb_cnt + 1 : 0;
    end

    assign ACK_I = STB_O && ack_en && (stb_cnt == wait_cfg);
    assign ERR_I = STB_O && err_en && (stb_cnt == wait_cfg);
    assign DAT_I = mem[ADR_O[9:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h40] <= 32'hAABBCCDD;
            mem[8'h41] <= 32'h11223344;
            mem[8'h42] <= 32'h55667788;
        end else if (STB_O && ACK_I && WE_O) begin
            if (SEL_O[3]) mem[ADR_O[9:2]][31:24] <= DAT_O[31:24];
            if (SEL_O[2]) mem[ADR_O[9:2]][23:16] <= DAT_O[23:16];
            if (SEL_O[1]) mem[ADR_O[9:2]][15:8]  <= DAT_O[15:8];
            if (SEL_O[0]) mem[ADR_O[9:2]][7:0]   <= DAT_O[7:0];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_wb(input logic [23:0] adr, input logic [3:0] sel, input logic we,
                           input logic [31:0] dat, input int len);
        wb_exp_t e;
        e.adr = adr; e.sel = sel; e.we = we; e.dat = dat; e.len = len;
        wb_q.push_back(e);
    endtask

    task automatic push_cpu(input logic err, input logic chk_d, input logic [15:0] d);
        cpu_exp_t e;
        e.err = err; e.chk_d = chk_d; e.d = d;
        cpu_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cyc"},   {31'b0, CYC_O}, 32'h0);
        chk({tag, "_stb"},   {31'b0, STB_O}, 32'h0);
        chk({tag, "_we"},    {31'b0, WE_O}, 32'h0);
        chk({tag, "_sel"},   {28'b0, SEL_O}, 32'h0);
        chk({tag, "_adr"},   {8'b0, ADR_O}, 32'h0);
        chk({tag, "_dat"},   DAT_O, 32'h0);
        chk({tag, "_dout"},  {16'b0, D_O}, 32'h0);
        chk({tag, "_resp"},  {30'b0, DTACK_n, BERR_n}, 32'h3);
    endtask

    // One CPU cycle; exp_lat is the number of clock edges from strobe sampling to DTACK/BERR.
    task automatic cpu_cycle(input string tag, input logic [23:0] addr, input logic rw,
                             input logic uds_n_i, input logic lds_n_i, input logic [15:0] wd,
                             input int exp_lat, input int hold, input logic [15:0] hold_d);
        int n;
        @(negedge clk);
        A = addr[23:1]; D_I = wd; RW = rw; UDS_n = uds_n_i; LDS_n = lds_n_i; AS_n = 1'b0;
        n = 0;
        while (DTACK_n && BERR_n && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_cyc_drop"}, {30'b0, CYC_O, STB_O}, 32'h0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_dout_hold"}, {16'b0, D_O}, {16'b0, hold_d});
        end
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        @(negedge clk);
        chk({tag, "_release"}, {30'b0, DTACK_n, BERR_n}, 32'h3);
    endtask

    // Monitor: compares Wishbone requests and CPU responses against the queues.
    logic stb_prev = 1'b0;
    logic dtack_prev = 1'b1;
    logic berr_prev = 1'b1;
    int   stb_run = 0;

    always @(negedge clk) begin
        wb_exp_t  we_e;
        cpu_exp_t ce;
        if (!DTACK_n && !BERR_n) chk("dtack_berr_exclusive", 32'h1, 32'h0);
        if (STB_O && !stb_prev) begin
            if (wb_q.size() == 0) begin
                chk("wb_unexpected", 32'h1, 32'h0);
            end else begin
                we_e = wb_q[0];
                chk("wb_adr", {8'b0, ADR_O}, {8'b0, we_e.adr});
                chk("wb_sel", {28'b0, SEL_O}, {28'b0, we_e.sel});
                chk("wb_we",  {31'b0, WE_O}, {31'b0, we_e.we});
                chk("wb_dat", DAT_O, we_e.dat);
                chk("wb_cyc", {31'b0, CYC_O}, 32'h1);
            end
        end
        if (STB_O) stb_run++;
        if (!STB_O && stb_prev) begin
            if (wb_q.size() != 0) begin
                we_e = wb_q.pop_front();
                if (we_e.len >= 0) chk("wb_stb_len", stb_run, we_e.len);
            end
            chk("wb_idle_ctl", {26'b0, CYC_O, WE_O, SEL_O}, 32'h0);
            stb_run = 0;
        end
        if ((!DTACK_n && dtack_prev) || (!BERR_n && berr_prev)) begin
            if (cpu_q.size() == 0) begin
                chk("cpu_unexpected", 32'h1, 32'h0);
            end else begin
                ce = cpu_q.pop_front();
                chk("cpu_berr", {31'b0, ~BERR_n}, {31'b0, ce.err});
                if (ce.chk_d) chk("cpu_dout", {16'b0, D_O}, {16'b0, ce.d});
            end
        end
        stb_prev   = STB_O;
        dtack_prev = DTACK_n;
        berr_prev  = BERR_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        A = '0; D_I = '0; RW = 1'b1; AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Word read, zero wait states
        ack_en = 1'b1; err_en = 1'b0; wait_cfg = 0;
        push_wb(24'h000100, 4'b1100, 1'b0, 32'h0, 1);
        push_cpu(1'b0, 1'b1, 16'hAABB);
        cpu_cycle("word_read", 24'h000100, 1'b1, 1'b0, 1'b0, 16'h0000, 2, 0, 16'h0);

        // Byte write to odd byte of upper halfword; D_O keeps last read data
        push_wb(24'h000100, 4'b0001, 1'b1, 32'h12341234, 1);
        push_cpu(1'b0, 1'b1, 16'hAABB);
        cpu_cycle("byte_write", 24'h000103, 1'b0, 1'b1, 1'b0, 16'h1234, 2, 0, 16'h0);

        // Readback of the written byte
        push_wb(24'h000100, 4'b0001, 1'b0, 32'h0, 1);
        push_cpu(1'b0, 1'b1, 16'hCC34);
        cpu_cycle("readback", 24'h000103, 1'b1, 1'b1, 1'b0, 16'h0000, 2, 0, 16'h0);

        // Three wait states, D_O held while AS_n stays low
        wait_cfg = 3;
        push_wb(24'h000104, 4'b1100, 1'b0, 32'h0, 4);
        push_cpu(1'b0, 1'b1, 16'h1122);
        cpu_cycle("wait3", 24'h000104, 1'b1, 1'b0, 1'b0, 16'h0000, 5, 3, 16'h1122);

        // No slave response: timeout of 4 gives 5 STB cycles
        ack_en = 1'b0; err_en = 1'b0;
        push_wb(24'h000108, 4'b1100, 1'b0, 32'h0, 5);
        push_cpu(1'b1, 1'b1, 16'h1122);
        cpu_cycle("timeout", 24'h000108, 1'b1, 1'b0, 1'b0, 16'h0000, 6, 0, 16'h0);

        // ERR_I and ACK_I together: error wins
        ack_en = 1'b1; err_en = 1'b1; wait_cfg = 1;
        push_wb(24'h00010C, 4'b1100, 1'b0, 32'h0, 2);
        push_cpu(1'b1, 1'b1, 16'h1122);
        cpu_cycle("err_ack", 24'h00010C, 1'b1, 1'b0, 1'b0, 16'h0000, 3, 0, 16'h0);

        // AS_n drops during BUS: slave cycle completes, no DTACK, D_O untouched
        err_en = 1'b0; wait_cfg = 3;
        push_wb(24'h000108, 4'b1100, 1'b0, 32'h0, 4);
        @(negedge clk);
        A = 23'h000084; RW = 1'b1; UDS_n = 1'b0; LDS_n = 1'b0; AS_n = 1'b0;
        @(negedge clk);
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_resp", {30'b0, DTACK_n, BERR_n}, 32'h3);
        end
        chk("abort_dout", {16'b0, D_O}, 32'h1122);

        // Reset while STB_O is high
        ack_en = 1'b0; wait_cfg = 0;
        push_wb(24'h000110, 4'b1100, 1'b0, 32'h0, -1);
        @(negedge clk);
        A = 23'h000088; RW = 1'b1; UDS_n = 1'b0; LDS_n = 1'b0; AS_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_stb", {31'b0, STB_O}, 32'h1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midreset");
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fresh read after reset
        ack_en = 1'b1; wait_cfg = 0;
        push_wb(24'h000100, 4'b1100, 1'b0, 32'h0, 1);
        push_cpu(1'b0, 1'b1, 16'hAABB);
        cpu_cycle("post_reset", 24'h000100, 1'b1, 1'b0, 1'b0, 16'h0000, 2, 0, 16'h0);

        repeat (3) @(negedge clk);
        chk("wb_queue_empty", wb_q.size(), 32'h0);
        chk("cpu_queue_empty", cpu_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m68k_wb_bridge.md
# m68k_wb_bridge

Wishbone bus master that turns one 68000-style 16-bit bus cycle (AS_n/UDS_n/LDS_n/RW, DTACK_n/BERR_n) into one 32-bit Wishbone classic cycle. It drives the memory and peripheral slaves, maps the big-endian byte strobes onto SEL, and returns read data or a bus error to the CPU side. A timeout converts a cycle that no slave answers into BERR.

## Interface

Parameters:
- ADR_WIDTH, 24: Wishbone address width in bits; ADR_O carries byte addresses.
- TIMEOUT, 255: number of cycles with STB_O high and no ACK_I/ERR_I before the bridge aborts; range 1..255.

Ports:
- CLK_I  in  1  single clock; all CPU-side inputs are synchronous to it.
- RST_I  in  1  reset, asynchronous, active-high.
- A  in  23  CPU address [23:1].
- D_I  in  16  CPU write data.
- D_O  out  16  CPU read data; held stable while DTACK_n is low.
- AS_n  in  1  address strobe, active-low.
- UDS_n  in  1  upper data strobe (even byte, D[15:8]), active-low.
- LDS_n  in  1  lower data strobe (odd byte, D[7:0]), active-low.
- RW  in  1  1 = read, 0 = write.
- DTACK_n  out  1  transfer acknowledge, active-low.
- BERR_n  out  1  bus error, active-low.
- ADR_O  out  ADR_WIDTH  Wishbone byte address, bits [1:0] always 0.
- DAT_O  out  32  Wishbone write data.
- DAT_I  in  32  Wishbone read data.
- SEL_O  out  4  byte selects.
- WE_O, CYC_O, STB_O  out  1 each  Wishbone control.
- ACK_I, ERR_I  in  1 each  Wishbone termination.

## Operation

States: IDLE, BUS, ACKD, FAIL.
- IDLE: when AS_n=0 and (UDS_n=0 or LDS_n=0), register the following, then go to BUS:
  - ADR_O = {A[ADR_WIDTH-1:2], 2'b00}.
  - WE_O = ~RW.
  - DAT_O = {D_I, D_I}.
  - SEL_O: A[1]=0 gives {~UDS_n, ~LDS_n, 0, 0}; A[1]=1 gives {0, 0, ~UDS_n, ~LDS_n}.
  - Load the timeout counter with TIMEOUT.
- BUS: CYC_O=STB_O=1.
  - ACK_I=1: capture D_O (A[1]=0 gives DAT_I[31:16], else DAT_I[15:0]; on writes D_O keeps its previous value). Go to ACKD.
  - ERR_I=1 (takes priority over ACK_I), or counter reaches 0: go to FAIL.
  - Otherwise decrement the counter.
- ACKD: DTACK_n=0. When AS_n=1, go to IDLE.
- FAIL: BERR_n=0. When AS_n=1, go to IDLE.
- On leaving BUS, CYC_O, STB_O, WE_O and SEL_O return to 0 on the same edge. ADR_O and DAT_O hold their values.
- If AS_n rises during BUS, the Wishbone cycle still runs to completion. The result is dropped, and the bridge returns to IDLE instead of ACKD/FAIL.
- Asynchronous reset, all outputs:
  - CYC_O=STB_O=WE_O=0, SEL_O=0, ADR_O=0, DAT_O=0, D_O=0.
  - DTACK_n=1, BERR_n=1.
  - State IDLE.
- Reset in mid-cycle drops CYC_O immediately; no ACK is expected afterwards.

## Timing

- Edge 0: strobes sampled in IDLE.
- Cycle 1: CYC_O/STB_O high.
- A slave that answers combinationally (ACK in the same cycle as STB) gives DTACK_n=0 from cycle 2. This is the minimum 68k-cycle-to-DTACK latency of 2 clocks.
- Each slave wait state adds 1 cycle.
- Timeout: FAIL is entered after exactly TIMEOUT+1 cycles of STB_O high.
- DTACK_n/BERR_n deassert 1 clock after AS_n=1 is sampled. A new cycle is accepted no earlier than the following edge.
- STB_O is never high for more than one transfer per AS_n assertion.
- DTACK_n and BERR_n are never both low.

## Structure

- Shared package m68kwb_pkg holds:
  - the state enum (IDLE, BUS, ACKD, FAIL);
  - a function for the SEL_O mapping;
  - the default TIMEOUT constant.
- One sub-module, wb_timeout: a loadable 8-bit down-counter with load, enable and a zero flag.
- All other logic sits in m68k_wb_bridge.

## Test plan

- Word read, A=0x000100, UDS_n=LDS_n=0, slave acks combinationally with DAT_I=0xAABBCCDD:
  - ADR_O=0x000100, SEL_O=4'b1100, WE_O=0;
  - D_O=0xAABB, DTACK_n=0 on cycle 2.
- Byte write, A=0x000103 (A[1]=1), LDS_n=0, UDS_n=1, D_I=0x1234:
  - SEL_O=4'b0001, DAT_O=0x12341234, WE_O=1;
  - a memory readback of that address returns byte 0x34.
- Slave holds ACK_I low for 3 cycles:
  - STB_O high for 4 cycles;
  - DTACK_n falls 1 cycle after ACK_I;
  - D_O stable until AS_n rises.
- No slave response, TIMEOUT=4:
  - BERR_n=0 after 5 STB_O cycles;
  - CYC_O=0 on the same edge;
  - BERR_n=1 one cycle after AS_n rises.
- ERR_I and ACK_I both asserted: BERR_n=0 and DTACK_n stays 1.
- Reset asserted while STB_O=1:
  - all outputs take reset values with no clock edge;
  - after reset a fresh read completes normally.
